// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch/jump flushes, mult/div busy tracking.
// Optional performance counters are built only when HAZ_STATS_EN is defined.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_use_hilo,
  input  logic        ID_jump,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rt,
  input  logic        EX_branch_taken,
  input  logic        EX_md_start,
  input  logic        EX_md_div,
  output logic        Stall_IF,
  output logic        Stall_ID,
  output logic        Flush_IF,
  output logic        Flush_ID,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use;
  logic       hilo_haz;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start while busy is ignored; a taken branch never aborts the unit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == MD_IDLE) begin
      if (EX_md_start) begin
        state_d = MD_BUSY;
        cnt_d   = EX_md_div ? DIV_LOAD : MUL_LOAD;
      end
    end else begin
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) state_d = MD_IDLE;
    end
  end

  assign md_busy = (state_q == MD_BUSY);
  assign md_done = md_busy && (cnt_q == 6'd1);

  assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                    ((ID_use_rs && (ID_rs == EX_rt)) || (ID_use_rt && (ID_rt == EX_rt)));
  assign hilo_haz = md_busy && (ID_use_hilo || EX_md_start);

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    Stall_IF = 1'b0;
    Stall_ID = 1'b0;
    Flush_IF = 1'b0;
    Flush_ID = 1'b0;
    if (EX_branch_taken) begin
      Flush_IF = 1'b1;
      Flush_ID = 1'b1;
    end else if (load_use || hilo_haz) begin
      Stall_IF = 1'b1;
      Stall_ID = 1'b1;
      Flush_ID = 1'b1;
    end else if (ID_jump) begin
      Flush_IF = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_ID) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush_IF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
